// File: rtl/seg16_scan_decoder.sv
// Receive-side 16-segment scan decoder: reassembles 6-digit multiplexed frames,
// filters glitches across frames and decodes back to ASCII. Optional macro SEG16_INV_EN.
module seg16_scan_decoder #(
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seg_in,
    input  logic [5:0]  dig_sel,
    input  logic        dig_valid,
    output logic [7:0]  char1,
    output logic [7:0]  char2,
    output logic [7:0]  char3,
    output logic [7:0]  char4,
    output logic [7:0]  char5,
    output logic [7:0]  char6,
    output logic        frame_done,
    output logic        sync_err,
    output logic [5:0]  bad_glyph,
    output logic        link_lost
);
    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    localparam int IW = $clog2(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] TMO_LAST = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] STB = 4'(STABLE_FRAMES);

    // Returns {bad_flag, ascii} for a committed pattern.
    function automatic logic [8:0] decode(input logic [15:0] p);
        case (p)
            16'h0FFF: decode = {1'b0, 8'h41};
            16'h0F7B: decode = {1'b0, 8'h42};
            16'h0A3F: decode = {1'b0, 8'h43};
            16'h0F77: decode = {1'b0, 8'h44};
            16'h0A7F: decode = {1'b0, 8'h45};
            16'h0A78: decode = {1'b0, 8'h46};
            16'h0000: decode = {1'b0, 8'h20};
            default:  decode = {1'b1, 8'h3F};
        endcase
    endfunction

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_idx, w_idx_nxt, w_store_idx;
    logic [IW-1:0]   r_idle, w_idle_nxt;
    logic            w_store, w_err, w_tmo;
    logic [15:0]     w_seg;
    logic [15:0]     r_slot [6];
    logic [15:0]     r_prev [6];
    logic [3:0]      r_cnt [6];
    logic [3:0]      w_cnt_nxt [6];
    logic [5:0]      w_upd;
    logic [8:0]      w_dec [6];
    logic [7:0]      r_char [6];
    logic [5:0]      r_bad;
    logic            r_frame_done, r_sync_err, r_link_lost;

`ifdef SEG16_INV_EN
    assign w_seg = ~seg_in;
`else
    assign w_seg = seg_in;
`endif

    // Next-state and slot-capture control.
    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_store_idx = r_idx;
        w_idx_nxt   = r_idx;
        w_idle_nxt  = r_idle;
        w_err       = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_HUNT, ST_COMMIT: begin
                if (dig_valid && dig_sel == 6'b000001) begin
                    w_store     = 1'b1;
                    w_store_idx = 3'd0;
                    w_idx_nxt   = 3'd1;
                    w_idle_nxt  = '0;
                    w_state_nxt = ST_COLLECT;
                end else begin
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_COLLECT: begin
                if (dig_valid) begin
                    w_idle_nxt = '0;
                    if (dig_sel == (6'b000001 << r_idx)) begin
                        w_store     = 1'b1;
                        w_store_idx = r_idx;
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = (r_idx == 3'd5) ? ST_COMMIT : ST_COLLECT;
                    end else begin
                        w_err = 1'b1;
                        if (dig_sel == 6'b000001) begin
                            w_store     = 1'b1;
                            w_store_idx = 3'd0;
                            w_idx_nxt   = 3'd1;
                            w_state_nxt = ST_COLLECT;
                        end else begin
                            w_state_nxt = ST_HUNT;
                        end
                    end
                end else if (r_idle == TMO_LAST) begin
                    w_err       = 1'b1;
                    w_tmo       = 1'b1;
                    w_idle_nxt  = '0;
                    w_state_nxt = ST_HUNT;
                end else begin
                    w_idle_nxt = r_idle + {{(IW-1){1'b0}}, 1'b1};
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    // Per-digit stability counter update and decode of captured slots.
    always_comb begin
        for (int n = 0; n < 6; n++) begin
            w_dec[n] = decode(r_slot[n]);
            if (r_slot[n] == r_prev[n]) begin
                w_cnt_nxt[n] = (r_cnt[n] >= STB) ? STB : r_cnt[n] + 4'd1;
            end else begin
                w_cnt_nxt[n] = 4'd1;
            end
            w_upd[n] = (w_cnt_nxt[n] == STB);
        end
    end

    // Frame assembly state: FSM, digit index, idle timer and slot capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_HUNT;
            r_idx   <= 3'd0;
            r_idle  <= '0;
            for (int n = 0; n < 6; n++) r_slot[n] <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_idle  <= w_idle_nxt;
            if (w_store) r_slot[w_store_idx] <= w_seg;
        end
    end

    // Commit path and status pulses; slots are read before any same-edge recapture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_link_lost  <= 1'b1;
            r_bad        <= 6'b000000;
            for (int n = 0; n < 6; n++) begin
                r_prev[n] <= 16'h0000;
                r_cnt[n]  <= 4'd0;
                r_char[n] <= 8'h20;
            end
        end else begin
            r_frame_done <= (r_state == ST_COMMIT);
            r_sync_err   <= w_err;
            if (w_tmo) begin
                r_link_lost <= 1'b1;
            end else if (r_state == ST_COMMIT) begin
                r_link_lost <= 1'b0;
            end
            if (r_state == ST_COMMIT) begin
                for (int n = 0; n < 6; n++) begin
                    r_prev[n] <= r_slot[n];
                    r_cnt[n]  <= w_cnt_nxt[n];
                    if (w_upd[n]) begin
                        r_char[n] <= w_dec[n][7:0];
                        r_bad[n]  <= w_dec[n][8];
                    end
                end
            end
        end
    end

    assign char1      = r_char[0];
    assign char2      = r_char[1];
    assign char3      = r_char[2];
    assign char4      = r_char[3];
    assign char5      = r_char[4];
    assign char6      = r_char[5];
    assign bad_glyph  = r_bad;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;
    assign link_lost  = r_link_lost;

endmodule

// File: tb/tb_seg16_scan_decoder.sv
// Directed self-checking bench for seg16_scan_decoder (STABLE_FRAMES=2, TIMEOUT_CYCLES=1024).
module tb_seg16_scan_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] seg_in = 16'h0000;
    logic [5:0]  dig_sel = 6'b000000;
    logic        dig_valid = 1'b0;
    logic [7:0]  ch [6];
    logic        frame_done, sync_err, link_lost;
    logic [5:0]  bad_glyph;

    int n_checks = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    int se_cnt = 0;
    int both_cnt = 0;
    int fd0, se0;
    logic [7:0] exp_ch [6];

    localparam logic [15:0] PA = 16'h0FFF, PB = 16'h0F7B, PC = 16'h0A3F;
    localparam logic [15:0] PD = 16'h0F77, PE = 16'h0A7F, PF = 16'h0A78;

    seg16_scan_decoder #(.STABLE_FRAMES(2), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel), .dig_valid(dig_valid),
        .char1(ch[0]), .char2(ch[1]), .char3(ch[2]), .char4(ch[3]), .char5(ch[4]), .char6(ch[5]),
        .frame_done(frame_done), .sync_err(sync_err), .bad_glyph(bad_glyph), .link_lost(link_lost)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled shortly after the falling edge.
    always begin
        @(negedge clk);
        #2;
        if (frame_done) fd_cnt++;
        if (sync_err) se_cnt++;
        if (frame_done && sync_err) both_cnt++;
    end

    task automatic strobe(input logic [5:0] sel, input logic [15:0] seg);
        dig_valid = 1'b1;
        dig_sel   = sel;
        seg_in    = seg;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        dig_valid = 1'b0;
        dig_sel   = 6'b000000;
        seg_in    = 16'h0000;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame6(input logic [15:0] s0, s1, s2, s3, s4, s5);
        strobe(6'b000001, s0);
        strobe(6'b000010, s1);
        strobe(6'b000100, s2);
        strobe(6'b001000, s3);
        strobe(6'b010000, s4);
        strobe(6'b100000, s5);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ch[i] !== 8'h20) begin n_fail++; $display("FAIL reset_char%0d got=%h exp=20", i + 1, ch[i]); end
        end
        n_checks++;
        if ({link_lost, frame_done, sync_err, bad_glyph} !== {1'b1, 1'b0, 1'b0, 6'b000000}) begin
            n_fail++;
            $display("FAIL reset_status got ll=%b fd=%b se=%b bg=%b exp ll=1 fd=0 se=0 bg=000000",
                     link_lost, frame_done, sync_err, bad_glyph);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_stable_commit;
        frame6(PA, PB, PC, PD, PE, PF);
        idle(1);
        n_checks++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL commit_fd1 got=%b exp=1", frame_done); end
        n_checks++;
        if (link_lost !== 1'b0) begin n_fail++; $display("FAIL commit_ll got=%b exp=0", link_lost); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ch[i] !== 8'h20) begin n_fail++; $display("FAIL commit_first_char%0d got=%h exp=20", i + 1, ch[i]); end
        end
        idle(1);
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL commit_fd_pulse got=%b exp=0", frame_done); end
        frame6(PA, PB, PC, PD, PE, PF);
        idle(1);
        exp_ch = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ch[i] !== exp_ch[i]) begin n_fail++; $display("FAIL commit_second_char%0d got=%h exp=%h", i + 1, ch[i], exp_ch[i]); end
        end
        idle(1);
    endtask

    task automatic test_glitch_filter;
        frame6(PA, PA, PA, PA, PA, PA);
        idle(1);
        frame6(PA, PA, PA, PA, PA, PA);
        idle(2);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ch[i] !== 8'h41) begin n_fail++; $display("FAIL glitch_base_char%0d got=%h exp=41", i + 1, ch[i]); end
        end
        fd0 = fd_cnt;
        frame6(PB, PA, PA, PA, PA, PA);
        idle(1);
        n_checks++;
        if (ch[0] !== 8'h41) begin n_fail++; $display("FAIL glitch_after_b got=%h exp=41", ch[0]); end
        frame6(PA, PA, PA, PA, PA, PA);
        idle(1);
        n_checks++;
        if (ch[0] !== 8'h41) begin n_fail++; $display("FAIL glitch_after_a1 got=%h exp=41", ch[0]); end
        frame6(PA, PA, PA, PA, PA, PA);
        idle(2);
        n_checks++;
        if (ch[0] !== 8'h41) begin n_fail++; $display("FAIL glitch_after_a2 got=%h exp=41", ch[0]); end
        n_checks++;
        if (fd_cnt - fd0 !== 3) begin n_fail++; $display("FAIL glitch_fd_count got=%0d exp=3", fd_cnt - fd0); end
    endtask

    task automatic test_sync_error;
        fd0 = fd_cnt;
        strobe(6'b000001, PB);
        strobe(6'b000010, PB);
        strobe(6'b001000, PB);
        n_checks++;
        if (sync_err !== 1'b1) begin n_fail++; $display("FAIL syncerr_pulse got=%b exp=1", sync_err); end
        idle(1);
        n_checks++;
        if (sync_err !== 1'b0) begin n_fail++; $display("FAIL syncerr_clear got=%b exp=0", sync_err); end
        strobe(6'b010000, PB);
        idle(3);
        n_checks++;
        if (fd_cnt - fd0 !== 0) begin n_fail++; $display("FAIL syncerr_no_fd got=%0d exp=0", fd_cnt - fd0); end
        n_checks++;
        if (ch[0] !== 8'h41 || ch[5] !== 8'h41) begin n_fail++; $display("FAIL syncerr_chars got=%h/%h exp=41/41", ch[0], ch[5]); end
        frame6(PB, PB, PB, PB, PB, PB);
        idle(1);
        n_checks++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL syncerr_recover_fd got=%b exp=1", frame_done); end
        idle(1);
    endtask

    task automatic test_timeout;
        se0 = se_cnt;
        strobe(6'b000001, PC);
        strobe(6'b000010, PC);
        strobe(6'b000100, PC);
        idle(1023);
        n_checks++;
        if (sync_err !== 1'b0 || se_cnt != se0) begin n_fail++; $display("FAIL timeout_early got=%b/%0d exp=0/0", sync_err, se_cnt - se0); end
        idle(1);
        n_checks++;
        if (sync_err !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse got=%b exp=1", sync_err); end
        n_checks++;
        if (link_lost !== 1'b1) begin n_fail++; $display("FAIL timeout_ll got=%b exp=1", link_lost); end
        n_checks++;
        if (ch[2] !== 8'h41) begin n_fail++; $display("FAIL timeout_chars got=%h exp=41", ch[2]); end
        idle(2);
        frame6(PB, PB, PB, PB, PB, PB);
        idle(1);
        n_checks++;
        if (link_lost !== 1'b0) begin n_fail++; $display("FAIL timeout_recover_ll got=%b exp=0", link_lost); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ch[i] !== 8'h42) begin n_fail++; $display("FAIL timeout_recover_char%0d got=%h exp=42", i + 1, ch[i]); end
        end
        idle(1);
    endtask

    task automatic test_bad_glyph;
        repeat (2) begin frame6(PA, PA, PA, 16'h1234, PA, PA); idle(1); end
        exp_ch = '{8'h41, 8'h41, 8'h41, 8'h3F, 8'h41, 8'h41};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ch[i] !== exp_ch[i]) begin n_fail++; $display("FAIL badglyph_char%0d got=%h exp=%h", i + 1, ch[i], exp_ch[i]); end
        end
        n_checks++;
        if (bad_glyph !== 6'b001000) begin n_fail++; $display("FAIL badglyph_flag got=%b exp=001000", bad_glyph); end
        repeat (2) begin frame6(PA, PA, PA, PC, PA, PA); idle(1); end
        n_checks++;
        if (ch[3] !== 8'h43) begin n_fail++; $display("FAIL badglyph_fix_char got=%h exp=43", ch[3]); end
        n_checks++;
        if (bad_glyph !== 6'b000000) begin n_fail++; $display("FAIL badglyph_fix_flag got=%b exp=000000", bad_glyph); end
    endtask

    task automatic test_inversion;
        logic [7:0] e_ch;
        logic [5:0] e_bad;
`ifdef SEG16_INV_EN
        e_ch = 8'h41; e_bad = 6'b000000;
`else
        e_ch = 8'h3F; e_bad = 6'b111111;
`endif
        repeat (2) begin frame6(16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000); idle(1); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ch[i] !== e_ch) begin n_fail++; $display("FAIL inv_char%0d got=%h exp=%h", i + 1, ch[i], e_ch); end
        end
        n_checks++;
        if (bad_glyph !== e_bad) begin n_fail++; $display("FAIL inv_bad got=%b exp=%b", bad_glyph, e_bad); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] pd_bus;
`ifdef SEG16_INV_EN
        pd_bus = ~PD;
`else
        pd_bus = PD;
`endif
        idle(2);
        fd0 = fd_cnt;
        frame6(pd_bus, pd_bus, pd_bus, pd_bus, pd_bus, pd_bus);
        frame6(pd_bus, pd_bus, pd_bus, pd_bus, pd_bus, pd_bus);
        idle(1);
        n_checks++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_fd got=%b exp=1", frame_done); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ch[i] !== 8'h44) begin n_fail++; $display("FAIL b2b_char%0d got=%h exp=44", i + 1, ch[i]); end
        end
        n_checks++;
        if (bad_glyph !== 6'b000000) begin n_fail++; $display("FAIL b2b_bad got=%b exp=000000", bad_glyph); end
        idle(2);
        n_checks++;
        if (fd_cnt - fd0 !== 2) begin n_fail++; $display("FAIL b2b_fd_count got=%0d exp=2", fd_cnt - fd0); end
    endtask

    task automatic test_restart;
        logic [15:0] pa_bus, pe_bus;
`ifdef SEG16_INV_EN
        pa_bus = ~PA; pe_bus = ~PE;
`else
        pa_bus = PA; pe_bus = PE;
`endif
        strobe(6'b000010, pa_bus);
        idle(1);
        n_checks++;
        if (sync_err !== 1'b0) begin n_fail++; $display("FAIL hunt_ignore got=%b exp=0", sync_err); end
        strobe(6'b000001, pa_bus);
        strobe(6'b000000, pa_bus);
        n_checks++;
        if (sync_err !== 1'b1) begin n_fail++; $display("FAIL zero_sel_err got=%b exp=1", sync_err); end
        strobe(6'b000001, pa_bus);
        strobe(6'b000010, pa_bus);
        strobe(6'b000001, pe_bus);
        n_checks++;
        if (sync_err !== 1'b1) begin n_fail++; $display("FAIL restart_err got=%b exp=1", sync_err); end
        strobe(6'b000010, pe_bus);
        strobe(6'b000100, pe_bus);
        strobe(6'b001000, pe_bus);
        strobe(6'b010000, pe_bus);
        strobe(6'b100000, pe_bus);
        idle(1);
        n_checks++;
        if (frame_done !== 1'b1 || ch[0] !== 8'h44) begin n_fail++; $display("FAIL restart_commit got fd=%b c1=%h exp fd=1 c1=44", frame_done, ch[0]); end
        frame6(pe_bus, pe_bus, pe_bus, pe_bus, pe_bus, pe_bus);
        idle(1);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ch[i] !== 8'h45) begin n_fail++; $display("FAIL restart_char%0d got=%h exp=45", i + 1, ch[i]); end
        end
        idle(2);
        n_checks++;
        if (both_cnt !== 0) begin n_fail++; $display("FAIL fd_se_overlap got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_stable_commit();
        test_glitch_filter();
        test_sync_error();
        test_timeout();
        test_bad_glyph();
        test_inversion();
        test_back_to_back();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
